ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
- Sequencing controller for the 256-point ML-KEM forward NTT; sits directly upstream of the butterfly unit (bu_ntt).
- Generates coefficient-RAM read addresses, twiddle (zeta) indices and write-back addresses for 7 layers × 128 Cooley-Tukey butterflies.
- Delays write-back addresses by the RAM read latency plus the butterfly pipeline latency so that they align with the A_Out/B_Out pair.
- Inserts a drain gap between layers to remove read-after-write hazards.

Parameters:
- MEM_LAT, 1: cycles from rd_en to read data valid at the butterfly inputs.
- BU_LAT, 17: cycles from butterfly input to A_Out/B_Out valid; must match the butterfly build.
- ADDR_W, 8: coefficient address width (N = 256).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a transform.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse at completion.
- rd_en  out  1  coefficient read strobe (dual port).
- rd_addr_a  out  ADDR_W  address of butterfly operand A.
- rd_addr_b  out  ADDR_W  address of butterfly operand B.
- tw_idx  out  7  zeta ROM index, aligned with rd_en.
- wr_en  out  1  write-back strobe for A_Out/B_Out.
- wr_addr_a  out  ADDR_W  write address for A_Out.
- wr_addr_b  out  ADDR_W  write address for B_Out.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0; FSM in IDLE; delay line cleared.
- Definition: L = MEM_LAT + BU_LAT.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 → READ; layer=0, bf=0.
  - start in any other state is ignored.
- READ:
  - rd_en=1 every cycle.
  - len = 128 >> layer; g = bf >> (7-layer); o = bf & (len-1).
  - rd_addr_a = g·2·len + o; rd_addr_b = rd_addr_a + len; tw_idx = (1 << layer) + g.
  - bf increments each cycle; after bf=127 → DRAIN, with the drain counter set to L.
- DRAIN:
  - rd_en=0 for exactly L cycles.
  - Then: if layer<6, layer++, bf=0, → READ; if layer=6 → DONE.
- DONE: done=1 for one cycle → IDLE.
- Outputs in all non-READ states: rd_en=0; rd_addr_a, rd_addr_b and tw_idx hold 0.
- Write-back: the {valid, addr_a, addr_b} issued with a read appears on wr_en/wr_addr_a/wr_addr_b exactly L cycles later. It is registered and carries no bubbles or reordering.
- busy: high from the cycle after start is accepted through the DONE cycle inclusive.
- Timing (start sampled at edge 0):
  - Reads of layer n occupy cycles 1+n(128+L) … 128+n(128+L).
  - Last wr_en occurs at cycle 896+7L.
  - done at cycle 897+7L, which is 1023 with the defaults.
- Hazard rule: the first read of layer n+1 is issued one cycle after the last write of layer n. RAM writes are synchronous, so that read returns the new data.
- Reset mid-operation: immediate return to IDLE; in-flight delay-line entries are discarded and no wr_en is issued after release. The next start begins at layer 0.
- start coincident with done: ignored, because state is DONE, not IDLE.

Optional Feature:
- Macro: NTT_CYC_CNT_EN.
- Defined:
  - Adds output cyc_cnt [15:0], reset to 0.
  - Cleared to 0 when start is accepted; increments every cycle while busy.
  - Holds its value after done until the next accepted start.
  - Expected value with defaults: 1023.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package ntt_pkg:
  - N=256, LOG_N=8, NUM_LAYERS=7, BF_PER_LAYER=128, Q=3329.
  - FSM state typedef/encodings.
  - Default MEM_LAT/BU_LAT constants.
- One sub-module ntt_dly: parameterised-depth, parameterised-width shift register with async active-low clear. It carries {valid, addr_a, addr_b} over L stages.
- Address arithmetic stays inline (shift/mask only; no multipliers).

Test Plan:
- Reset: hold rst_n=0, toggle start → all outputs 0, busy=0; release → still idle.
- Layer 0: start=1 (cycle 0) → cycles 1,2,3 read (0,128,tw1), (1,129,tw1), (2,130,tw1). wr_en first at cycle 19 with wr_addr (0,128).
- Layer 6: check bf0 → (0,2,tw64), bf1 → (1,3,tw64), bf2 → (4,6,tw65), bf127 → (253,255,tw127).
- Drain and completion:
  - Gap between layer reads is exactly 18 idle cycles.
  - No read is issued while its address is still pending write.
  - 896 total wr_en.
  - done at cycle 1023; busy falls at cycle 1024.
  - With NTT_CYC_CNT_EN: cyc_cnt=1023.
- Ignored start: start pulsed at cycle 500 and during the done cycle → no restart, same address stream; a start at cycle 1025 is accepted.
- Reset mid-operation: rst_n=0 during layer 3 → outputs 0 within the same cycle; no wr_en after release; a new start reproduces the layer-0 stream exactly.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the ML-KEM forward-NTT sequencer.
// Optional cycle counter is enabled by defining NTT_CYC_CNT_EN.
package ntt_pkg;

    localparam int unsigned N            = 256;
    localparam int unsigned LOG_N        = 8;
    localparam int unsigned NUM_LAYERS   = 7;
    localparam int unsigned BF_PER_LAYER = 128;
    localparam int unsigned Q            = 3329;

    localparam int unsigned MEM_LAT_DEF  = 1;
    localparam int unsigned BU_LAT_DEF   = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control/address bundle between the NTT sequencer, its host and the RAM/butterfly.
// cyc_cnt exists only when NTT_CYC_CNT_EN is defined.
interface ntt_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [6:0]        tw_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
`ifdef NTT_CYC_CNT_EN
    logic [15:0]       cyc_cnt;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b, cyc_cnt
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b, cyc_cnt
    );
`else
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b
    );
`endif
endinterface

// File: rtl/ntt_dly.sv
// Fixed-depth shift register with asynchronous clear; aligns write-back
// addresses with the butterfly outputs.
module ntt_dly #(
    parameter int unsigned DEPTH = 18,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer for the 256-point forward NTT: read/twiddle/write-back addressing
// over 7 layers with inter-layer drain. Define NTT_CYC_CNT_EN for cyc_cnt.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned BU_LAT  = BU_LAT_DEF,
    parameter int unsigned ADDR_W  = LOG_N
) (
    input logic        clk,
    input logic        rst_n,
    ntt_ctrl_if.master bus
);

    localparam int unsigned         L          = MEM_LAT + BU_LAT;
    localparam int unsigned         DRAIN_W    = $clog2(L + 1);
    localparam int unsigned         DLY_W      = 2 * ADDR_W + 1;
    localparam logic [2:0]          LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [6:0]          LAST_BF    = 7'(BF_PER_LAYER - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_INIT = DRAIN_W'(L);
    localparam logic [DRAIN_W-1:0]  DRAIN_ONE  = DRAIN_W'(1);

    ntt_state_e          r_state;
    ntt_state_e          w_state_next;
    logic [2:0]          r_layer;
    logic [6:0]          r_bf;
    logic [DRAIN_W-1:0]  r_drain;

    logic                w_accept;
    logic                w_busy;
    logic                w_done;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_len;
    logic [6:0]          w_g;
    logic [ADDR_W-1:0]   w_addr_a;
    logic [ADDR_W-1:0]   w_addr_b;
    logic [6:0]          w_tw;
    logic [DLY_W-1:0]    w_dly_q;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_READ;
            ST_READ:  if (r_bf == LAST_BF) w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (r_drain == DRAIN_ONE) begin
                    w_state_next = (r_layer == LAST_LAYER) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // bf wraps 127 -> 0 naturally, so the next layer starts at bf 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer <= '0;
            r_bf    <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_layer <= '0;
                        r_bf    <= '0;
                    end
                end
                ST_READ: begin
                    r_bf <= r_bf + 7'd1;
                    if (r_bf == LAST_BF) r_drain <= DRAIN_INIT;
                end
                ST_DRAIN: begin
                    r_drain <= r_drain - DRAIN_ONE;
                    if (r_drain == DRAIN_ONE && r_layer != LAST_LAYER) begin
                        r_layer <= r_layer + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // a = g*2*len + o, built from disjoint bit fields since len is a power of two.
    always_comb begin
        w_busy   = (r_state != ST_IDLE);
        w_done   = (r_state == ST_DONE);
        w_rd_en  = 1'b0;
        w_len    = '0;
        w_g      = '0;
        w_addr_a = '0;
        w_addr_b = '0;
        w_tw     = '0;
        if (r_state == ST_READ) begin
            w_rd_en  = 1'b1;
            w_len    = ADDR_W'(BF_PER_LAYER) >> r_layer;
            w_g      = r_bf >> (3'd7 - r_layer);
            w_addr_a = (ADDR_W'(w_g) << (4'd8 - {1'b0, r_layer}))
                     | (ADDR_W'(r_bf) & (w_len - ADDR_W'(1)));
            w_addr_b = w_addr_a + w_len;
            w_tw     = (7'd1 << r_layer) + w_g;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr_a = w_addr_a;
    assign bus.rd_addr_b = w_addr_b;
    assign bus.tw_idx    = w_tw;

    ntt_dly #(
        .DEPTH (L),
        .WIDTH (DLY_W)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({w_rd_en, w_addr_a, w_addr_b}),
        .o_q   (w_dly_q)
    );

    assign bus.wr_en     = w_dly_q[DLY_W-1];
    assign bus.wr_addr_a = w_dly_q[2*ADDR_W-1:ADDR_W];
    assign bus.wr_addr_b = w_dly_q[ADDR_W-1:0];

`ifdef NTT_CYC_CNT_EN
    logic [15:0] r_cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
        end else if (w_accept) begin
            r_cyc_cnt <= '0;
        end else if (w_busy) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
        end
    end

    assign bus.cyc_cnt = r_cyc_cnt;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: closed-form timeline model compared every cycle,
// plus literal address pins, hazard tracking, ignored-start and mid-run reset cases.
module tb_ntt_ctrl;

    localparam int L   = 18;
    localparam int P   = 128 + L;
    localparam int D   = 7 * P + 1;
    localparam int NWR = 896;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_ctrl_if #(.ADDR_W(8)) bus ();

    ntt_ctrl #(
        .MEM_LAT (1),
        .BU_LAT  (17),
        .ADDR_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [6:0] tw;
        logic       wr_en;
        logic [7:0] wa;
        logic [7:0] wb;
    } obs_t;

    int checks      = 0;
    int failures    = 0;
    int ecnt        = 0;
    bit m_active    = 1'b0;
    int m_s         = 0;
    int wr_total    = 0;
    int hazards     = 0;
    int last_done_r = -1;
    int last_fall_r = -1;
    logic prev_busy = 1'b0;
    bit pend [256];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Read issued at cycle r after the accepting edge (r = 1 is the first read).
    function automatic void read_of(input int r, output logic v, output logic [7:0] a,
                                    output logic [7:0] b, output logic [6:0] tw);
        int n, k, len, g;
        v = 1'b0; a = '0; b = '0; tw = '0;
        if (r < 1) return;
        n = (r - 1) / P;
        k = (r - 1) % P;
        if (n >= 7 || k >= 128) return;
        len = 128 >> n;
        g   = k / len;
        v   = 1'b1;
        a   = 8'(2 * g * len + k % len);
        b   = 8'(2 * g * len + k % len + len);
        tw  = 7'((1 << n) + g);
    endfunction

    function automatic obs_t model(input int r, input bit active);
        obs_t o;
        logic v, wv;
        logic [7:0] a, b, wa, wb;
        logic [6:0] tw, wtw;
        o = '0;
        if (!active) return o;
        read_of(r, v, a, b, tw);
        read_of(r - L, wv, wa, wb, wtw);
        o.busy  = (r >= 1 && r <= D);
        o.done  = (r == D);
        o.rd_en = v;
        o.ra    = a;
        o.rb    = b;
        o.tw    = tw;
        o.wr_en = wv;
        o.wa    = wa;
        o.wb    = wb;
        return o;
    endfunction

    always @(posedge clk) ecnt <= ecnt + 1;

    // A start is taken only once the previous run's done cycle has passed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
        end else if (bus.start && (!m_active || ecnt - m_s > D)) begin
            m_active <= 1'b1;
            m_s      <= ecnt;
        end
    end

    task automatic pin_rd(input string name, input int a, input int b, input int tw);
        check(name, {bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx},
              {1'b1, 8'(a), 8'(b), 7'(tw)});
    endtask

    always @(negedge clk) begin : compare
        obs_t e, a;
        int r;
        r = ecnt - m_s;
        e = model(r, m_active);
        a.busy  = bus.busy;
        a.done  = bus.done;
        a.rd_en = bus.rd_en;
        a.ra    = bus.rd_addr_a;
        a.rb    = bus.rd_addr_b;
        a.tw    = bus.tw_idx;
        a.wr_en = bus.wr_en;
        a.wa    = bus.wr_addr_a;
        a.wb    = bus.wr_addr_b;
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle ecnt=%0d r=%0d got=%h exp=%h", ecnt, r, a, e);
        end
`ifdef NTT_CYC_CNT_EN
        begin
            int ec;
            ec = !m_active ? 0 : (r < 1 ? 0 : (r - 1 > D ? D : r - 1));
            check("cyc_cnt", bus.cyc_cnt, ec);
        end
`endif
        if (m_active) begin
            case (r)
                1:           pin_rd("pin_l0_bf0", 0, 128, 1);
                2:           pin_rd("pin_l0_bf1", 1, 129, 1);
                3:           pin_rd("pin_l0_bf2", 2, 130, 1);
                6 * P + 1:   pin_rd("pin_l6_bf0", 0, 2, 64);
                6 * P + 2:   pin_rd("pin_l6_bf1", 1, 3, 64);
                6 * P + 3:   pin_rd("pin_l6_bf2", 4, 6, 65);
                6 * P + 128: pin_rd("pin_l6_bf127", 253, 255, 127);
                19: check("pin_first_wr", {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b},
                          {1'b1, 8'd0, 8'd128});
                default: ;
            endcase
        end
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) pend[i] = 1'b0;
        end else begin
            // Read checked before same-cycle writes clear: such a read would see stale data.
            if (bus.rd_en) begin
                if (pend[bus.rd_addr_a] || pend[bus.rd_addr_b]) hazards++;
                pend[bus.rd_addr_a] = 1'b1;
                pend[bus.rd_addr_b] = 1'b1;
            end
            if (bus.wr_en) begin
                wr_total++;
                pend[bus.wr_addr_a] = 1'b0;
                pend[bus.wr_addr_b] = 1'b0;
            end
        end
        if (bus.done) last_done_r = r;
        if (prev_busy && !bus.busy) last_fall_r = r;
        prev_busy = bus.busy;
    end

    task automatic wait_until(input int x);
        while (ecnt < x) @(negedge clk);
        #1;
    endtask

    task automatic pulse_at(input int x);
        wait_until(x);
        bus.start = 1'b1;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        longint v;
        v = {bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx,
             bus.wr_en, bus.wr_addr_a, bus.wr_addr_b};
`ifdef NTT_CYC_CNT_EN
        v = v | longint'(bus.cyc_cnt);
`endif
        check(name, v, 0);
    endtask

    initial begin : stim
        int s1, s2, s3, rx, w0, w1;
        bus.start = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = ~bus.start;
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("idle_after_release");

        // Run 1: full transform with ignored starts mid-run and on the done cycle.
        w0 = wr_total;
        s1 = ecnt;
        pulse_at(s1);
        pulse_at(s1 + 500);
        pulse_at(s1 + 600 + int'($urandom_range(0, 300)));
        pulse_at(s1 + D);
        wait_until(s1 + D + 2);
        check("run1_wr_count", wr_total - w0, NWR);
        check("run1_done_r", last_done_r, 1023);
        check("run1_busy_fall_r", last_fall_r, 1024);
        check("run1_done_restart_ignored", bus.busy, 0);

        // Run 2: accepted two cycles after done, then reset inside layer 3.
        s2 = ecnt;
        pulse_at(s2);
        rx = s2 + 3 * P + 1 + int'($urandom_range(0, 127));
        wait_until(rx);
        check("layer3_reading", bus.rd_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w1 = wr_total;
        repeat (40) @(negedge clk);
        #1;
        check("no_wr_after_reset", wr_total - w1, 0);

        // Run 3: fresh start after a random gap must replay from layer 0.
        repeat (int'($urandom_range(1, 20))) @(negedge clk);
        last_done_r = -1;
        last_fall_r = -1;
        w0 = wr_total;
        s3 = ecnt;
        pulse_at(s3);
        pulse_at(s3 + 100 + int'($urandom_range(0, 800)));
        wait_until(s3 + D + 3);
        check("run3_wr_count", wr_total - w0, NWR);
        check("run3_done_r", last_done_r, 1023);
        check("run3_busy_fall_r", last_fall_r, 1024);
`ifdef NTT_CYC_CNT_EN
        check("run3_cyc_cnt", bus.cyc_cnt, 1023);
`endif
        check("hazards", hazards, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
